vid_in_axis_sync_ctrl: RTL and testbench

- Sequencing controller for the 16-bit video-in to AXI4-Stream bridge.
- Drives the bridge's `axis_enable` and `rst`, and aligns stream start to a frame boundary (vsync followed by tuser).
- Snoops the bridge's master AXIS handshake to police line length and SOF placement.
- Recovers from FIFO write overflow (`wr_error`) by flush/resync, and reports lock status and error counts to software.

---
 rtl/vid_in_axis_sync_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_vid_in_axis_sync_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_in_axis_sync_ctrl.sv
// vid_in_axis_sync_ctrl
// Sequencing controller for the 16-bit video-in to AXI4-Stream bridge.
// Flushes the bridge, aligns the stream to vsync + tuser, polices line length
// and SOF placement on the snooped master AXIS, and recovers from FIFO
// overflow by flush/resync.
// Optional sticky interrupt logic: define VID_IN_SYNC_CTRL_IRQ_EN.
module vid_in_axis_sync_ctrl #(
    parameter int C_HSIZE_WIDTH  = 12,
    parameter int C_FLUSH_CYCLES = 16,
    parameter int C_LOCK_FRAMES  = 2,
    parameter int C_CNT_WIDTH    = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     ctrl_enable,
    input  logic [C_HSIZE_WIDTH-1:0] cfg_hsize,
    input  logic                     vtd_vsync,
    input  logic                     wr_error,
    input  logic                     mon_tvalid,
    input  logic                     mon_tready,
    input  logic                     mon_tuser,
    input  logic                     mon_tlast,
    output logic                     axis_enable,
    output logic                     bridge_rst,
    output logic                     locked,
    output logic                     busy,
    output logic [C_CNT_WIDTH-1:0]   frame_count,
    output logic [C_CNT_WIDTH-1:0]   err_count,
    output logic                     irq,
    input  logic                     irq_clr
);

    localparam int HW = C_HSIZE_WIDTH;
    localparam int FW = (C_FLUSH_CYCLES > 2) ? $clog2(C_FLUSH_CYCLES) : 1;
    localparam int GW = (C_LOCK_FRAMES > 1) ? $clog2(C_LOCK_FRAMES + 1) : 1;
    localparam logic [GW-1:0] LOCK_N = GW'(C_LOCK_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_WAIT_VS, S_ARM, S_RUN, S_STOP
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      vs_sync, ovf_sync;
    logic [FW-1:0]   flush_cnt;
    logic [HW-1:0]   hsize, pix_cnt, pix_inc;
    logic [GW-1:0]   good_frames, good_inc;
    logic            frame_err;
    logic            axis_en_d, bridge_rst_d, busy_d;

    logic vs_rise, ovf_rise, beat, streaming, flush_done;
    logic ovf_evt, line_err, sof_err, arm_sof, arm_err, mon_beat;
    logic stream_err, sof_good, err_evt;

    // two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vs_sync  <= '0;
            ovf_sync <= '0;
        end else begin
            vs_sync  <= {vs_sync[1:0], vtd_vsync};
            ovf_sync <= {ovf_sync[1:0], wr_error};
        end
    end

    assign vs_rise    = vs_sync[1] & ~vs_sync[2];
    assign ovf_rise   = ovf_sync[1] & ~ovf_sync[2];
    assign beat       = mon_tvalid & mon_tready;
    assign streaming  = (state == S_RUN) || (state == S_STOP);
    assign flush_done = (state == S_FLUSH) && (flush_cnt == '0);

    // Beat policing: the pixel count saturates so a runaway line cannot wrap
    // back into a false match against hsize.
    assign pix_inc  = (pix_cnt == '1) ? pix_cnt : pix_cnt + 1'b1;
    assign line_err = mon_tlast ? (pix_inc != hsize) : (pix_inc == hsize);
    assign sof_err  = mon_tuser && (pix_cnt != '0);
    assign good_inc = (good_frames == LOCK_N) ? good_frames : good_frames + 1'b1;

    // Overflow pre-empts whatever the same-cycle beat would have done.
    assign ovf_evt    = ovf_rise && ((state == S_ARM) || streaming);
    assign arm_sof    = (state == S_ARM) && ctrl_enable && beat && mon_tuser && !ovf_evt;
    assign arm_err    = (state == S_ARM) && ctrl_enable && beat && !mon_tuser && !ovf_evt;
    assign mon_beat   = streaming && beat && !ovf_evt;
    assign stream_err = mon_beat && (line_err || sof_err);
    assign sof_good   = mon_beat && mon_tuser && (pix_cnt == '0) && !frame_err && !line_err;
    assign err_evt    = ovf_evt || stream_err || arm_err;

    // state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ctrl_enable) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_done) state_nxt = ctrl_enable ? S_WAIT_VS : S_IDLE;
            end
            S_WAIT_VS: begin
                if (!ctrl_enable)  state_nxt = S_IDLE;
                else if (vs_rise)  state_nxt = S_ARM;
            end
            S_ARM: begin
                if (ovf_rise)          state_nxt = S_FLUSH;
                else if (!ctrl_enable) state_nxt = S_IDLE;
                else if (beat)         state_nxt = mon_tuser ? S_RUN : S_FLUSH;
            end
            S_RUN: begin
                // a stop request on a line-ending beat needs no drain
                if (ovf_rise)          state_nxt = S_FLUSH;
                else if (!ctrl_enable) state_nxt = (beat && mon_tlast) ? S_IDLE : S_STOP;
            end
            S_STOP: begin
                if (ovf_rise || (beat && mon_tlast)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // output decode from the current state
    always_comb begin
        axis_en_d    = (state == S_ARM) || streaming;
        bridge_rst_d = (state == S_FLUSH);
        busy_d       = (state != S_IDLE);
    end

    // registered bridge controls
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axis_enable <= 1'b0;
            bridge_rst  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            axis_enable <= axis_en_d;
            bridge_rst  <= bridge_rst_d;
            busy        <= busy_d;
        end
    end

    // flush timer, line/frame tracking, lock and statistics counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            flush_cnt   <= '0;
            hsize       <= HW'(1);
            pix_cnt     <= '0;
            frame_err   <= 1'b1;
            good_frames <= '0;
            locked      <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (state != S_FLUSH)    flush_cnt <= FW'(C_FLUSH_CYCLES - 1);
            else if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;

            // zero-width lines are meaningless; run them as single-pixel lines
            if (flush_done) hsize <= (cfg_hsize == '0) ? HW'(1) : cfg_hsize;

            // frame_err: something went wrong since the last SOF
            if (state == S_FLUSH) begin
                pix_cnt   <= '0;
                frame_err <= 1'b1;
            end else if (arm_sof) begin
                // a single-pixel line ends on its SOF beat
                pix_cnt   <= mon_tlast ? '0 : HW'(1);
                frame_err <= 1'b0;
            end else if (mon_beat) begin
                pix_cnt   <= mon_tlast ? '0 : pix_inc;
                frame_err <= mon_tuser ? (line_err || sof_err)
                                       : (frame_err || line_err || sof_err);
            end

            if ((state == S_FLUSH) || err_evt) good_frames <= '0;
            else if (sof_good)                 good_frames <= good_inc;

            if (!streaming || err_evt)              locked <= 1'b0;
            else if (sof_good && good_inc == LOCK_N) locked <= 1'b1;

            if ((arm_sof || (mon_beat && mon_tuser)) && frame_count != '1)
                frame_count <= frame_count + 1'b1;

            if (err_evt && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

`ifdef VID_IN_SYNC_CTRL_IRQ_EN
    logic irq_ovf, irq_line, irq_lock, locked_d, irq_q;

    // sticky causes: a set event in the same cycle as irq_clr wins
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_ovf  <= 1'b0;
            irq_line <= 1'b0;
            irq_lock <= 1'b0;
            locked_d <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            locked_d <= locked;
            irq_ovf  <= ovf_evt                 || (irq_ovf  && !irq_clr);
            irq_line <= (stream_err || arm_err) || (irq_line && !irq_clr);
            irq_lock <= (locked && !locked_d)   || (irq_lock && !irq_clr);
            irq_q    <= irq_ovf || irq_line || irq_lock;
        end
    end

    assign irq = irq_q;
`else
    // no interrupt logic in this build; irq_clr has nothing to clear
    assign irq = 1'b0 & irq_clr;
`endif

endmodule

// File: tb/tb_vid_in_axis_sync_ctrl.sv
// Scoreboard bench for vid_in_axis_sync_ctrl (hsize 8, 4-cycle flush).
// Stimulus queues expected output snapshots and expected flush pulse widths;
// one monitor compares them against the DUT.
module tb_vid_in_axis_sync_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn, ctrl_enable, vtd_vsync, wr_error, irq_clr;
    logic [11:0] cfg_hsize;
    logic        mon_tvalid, mon_tready, mon_tuser, mon_tlast;
    logic        axis_enable, bridge_rst, locked, busy, irq;
    logic [15:0] frame_count, err_count;

    vid_in_axis_sync_ctrl #(
        .C_HSIZE_WIDTH(12), .C_FLUSH_CYCLES(4), .C_LOCK_FRAMES(2), .C_CNT_WIDTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .ctrl_enable(ctrl_enable), .cfg_hsize(cfg_hsize),
        .vtd_vsync(vtd_vsync), .wr_error(wr_error),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
        .axis_enable(axis_enable), .bridge_rst(bridge_rst), .locked(locked), .busy(busy),
        .frame_count(frame_count), .err_count(err_count), .irq(irq), .irq_clr(irq_clr)
    );

    always #5 aclk = ~aclk;

`ifdef VID_IN_SYNC_CTRL_IRQ_EN
    localparam bit IK = 1'b0;   // irq follows lock/error history; checked separately
`else
    localparam bit IK = 1'b1;
`endif

    typedef struct packed {
        logic ae, br, lk, bz, ir, ik;
        logic [15:0] fc, ec;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    flush_q[$];
    int    n_chk = 0, n_pass = 0, fw = 0;
    bit    done = 1'b0, fin = 1'b0;

    // monitor: snapshot scoreboard, flush pulse width, end-of-run drain
    always @(negedge aclk) begin
        snap_t e;
        string nm;
        int    ew;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (axis_enable === e.ae && bridge_rst === e.br && locked === e.lk && busy === e.bz &&
                frame_count === e.fc && err_count === e.ec && (!e.ik || irq === e.ir))
                n_pass++;
            else
                $display("FAIL %s: got ae=%0b br=%0b lk=%0b busy=%0b irq=%0b fc=%0d ec=%0d, want ae=%0b br=%0b lk=%0b busy=%0b irq=%0b(chk %0b) fc=%0d ec=%0d",
                         nm, axis_enable, bridge_rst, locked, busy, irq, frame_count, err_count,
                         e.ae, e.br, e.lk, e.bz, e.ir, e.ik, e.fc, e.ec);
        end
        if (bridge_rst === 1'b1) fw++;
        else if (fw > 0) begin
            n_chk++;
            if (flush_q.size() == 0)
                $display("FAIL flush_pulse: got unexpected %0d-cycle pulse, want none", fw);
            else begin
                ew = flush_q.pop_front();
                if (fw == ew) n_pass++;
                else $display("FAIL flush_pulse: got %0d cycles, want %0d", fw, ew);
            end
            fw = 0;
        end
        if (done && !fin) begin
            n_chk++;
            if (flush_q.size() == 0 && exp_q.size() == 0 && fw == 0) n_pass++;
            else $display("FAIL drain: got %0d flush pulses and %0d snapshots outstanding, want 0",
                          flush_q.size(), exp_q.size());
            $display("%0d/%0d checks passed", n_pass, n_chk);
            fin = 1'b1;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want end of stimulus");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic beat(input bit u, input bit l);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = u; mon_tlast = l;
        tick(1);
        mon_tvalid = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
    endtask

    // offered but not accepted: must be ignored
    task automatic stall();
        mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tuser = 1'b1; mon_tlast = 1'b1;
        tick(1);
        mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tuser = 1'b0; mon_tlast = 1'b0;
    endtask

    task automatic line(input bit sof, input int n);
        for (int i = 0; i < n; i++) beat(sof && i == 0, i == n - 1);
    endtask

    task automatic frame();
        line(1'b1, 8);
        line(1'b0, 8);
    endtask

    task automatic vsync();
        vtd_vsync = 1'b1; tick(2); vtd_vsync = 1'b0; tick(4);
    endtask

    task automatic expect_snap(input string nm, input bit ae, br, lk, bz, ir, ik,
                               input int fc, ec);
        snap_t s;
        s.ae = ae; s.br = br; s.lk = lk; s.bz = bz; s.ir = ir; s.ik = ik;
        s.fc = 16'(fc); s.ec = 16'(ec);
        exp_q.push_back(s);
        name_q.push_back(nm);
        @(negedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input bit ae, br, lk, bz, input int fc, ec);
        expect_snap(nm, ae, br, lk, bz, 1'b0, IK, fc, ec);
    endtask

    initial begin
        aresetn = 1'b0; ctrl_enable = 1'b0; cfg_hsize = 12'd8; vtd_vsync = 1'b0;
        wr_error = 1'b0; irq_clr = 1'b0;
        mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tuser = 1'b0; mon_tlast = 1'b0;
        tick(3);
        aresetn = 1'b1;
        tick(1);
        chk("reset", 0, 0, 0, 0, 0, 0);

        // bring-up: 4-cycle flush, then vsync arms the stream
        flush_q.push_back(4);
        ctrl_enable = 1'b1;
        tick(10);
        vsync();
        chk("armed", 1, 0, 0, 1, 0, 0);
        frame();
        stall();
        frame();
        chk("two_frames", 1, 0, 0, 1, 2, 0);
        frame();
        chk("locked_3rd_sof", 1, 0, 1, 1, 3, 0);

        // short line: tlast on the 6th beat, stay in RUN
        line(1'b1, 6);
        chk("short_line", 1, 0, 0, 1, 4, 1);
        line(1'b0, 8);
        frame();
        frame();
        chk("relock_pending", 1, 0, 0, 1, 6, 1);
        frame();
        chk("relocked", 1, 0, 1, 1, 7, 1);

        // overflow lands on the same beat as a short tlast
        flush_q.push_back(4);
        beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        wr_error = 1'b1;
        beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
        wr_error = 1'b0;
        tick(1);
        chk("overflow", 0, 1, 0, 1, 8, 2);
        tick(8);

        // non-SOF beat while armed
        vsync();
        chk("armed_again", 1, 0, 0, 1, 8, 2);
        flush_q.push_back(4);
        beat(1'b0, 1'b0);
        tick(1);
        chk("arm_error", 0, 1, 0, 1, 8, 3);
        tick(8);

        // graceful stop at pix_cnt 3, drains to the end of the line
        vsync();
        beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        ctrl_enable = 1'b0;
        tick(2);
        chk("stopping", 1, 0, 0, 1, 9, 3);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0);
        chk("stop_hold", 1, 0, 0, 1, 9, 3);
        beat(1'b0, 1'b1);
        tick(1);
        chk("stop_done", 0, 0, 0, 0, 9, 3);

`ifdef VID_IN_SYNC_CTRL_IRQ_EN
        irq_clr = 1'b1; tick(1); irq_clr = 1'b0; tick(2);
        expect_snap("irq_cleared", 0, 0, 0, 0, 0, 1, 9, 3);
        flush_q.push_back(4);
        ctrl_enable = 1'b1;
        tick(10);
        vsync();
        beat(1'b1, 1'b0); beat(1'b1, 1'b0);
        tick(2);
        expect_snap("irq_sof_err", 1, 0, 0, 1, 1, 1, 11, 4);
        irq_clr = 1'b1;
        beat(1'b0, 1'b1);
        irq_clr = 1'b0;
        tick(1);
        expect_snap("irq_clr_vs_set", 1, 0, 0, 1, 1, 1, 11, 5);
        irq_clr = 1'b1; tick(1); irq_clr = 1'b0; tick(2);
        expect_snap("irq_clr_only", 1, 0, 0, 1, 0, 1, 11, 5);
`endif

        tick(3);
        done = 1'b1;
        tick(3);
        $finish;
    end

endmodule
